// File: rtl/fir_pkg.sv
// Constants and FSM state encoding shared by the FIR coefficient loader and W4823_FIR.
package fir_pkg;

   localparam int FIR_NTAPS = 64;
   localparam int FIR_AW    = 6;
   localparam int FIR_CW    = 17;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_B0   = 3'd1,
      ST_B1   = 3'd2,
      ST_B2   = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } state_t;

endpackage

// File: rtl/fir_coef_loader_if.sv
// Byte-stream input and FIR coefficient write port of the loader; master is the byte source / FIR side.
interface fir_coef_loader_if import fir_pkg::*; #(
   parameter int AW = FIR_AW,
   parameter int CW = FIR_CW
);

   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic [CW-1:0] cin;
   logic [AW-1:0] caddr;
   logic          cload;

   modport master (output byte_in, byte_valid, input byte_ready, cin, caddr, cload);
   modport slave  (input byte_in, byte_valid, output byte_ready, cin, caddr, cload);

endinterface

// File: rtl/fir_coef_asm.sv
// Purpose: merges three MSB-first bytes into a 17-bit coefficient and flags nonzero pad bits.
// Latency: coef_nxt is combinational on the final byte; upper bits registered as bytes 0/1 arrive.
// Backpressure: none; captures only when byte_take is high.
module fir_coef_asm import fir_pkg::*; (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic [7:0]        byte_in,
   input  logic              byte_take,
   input  logic [1:0]        byte_idx,
   output logic [FIR_CW-1:0] coef_nxt,
   output logic              pad_err
);

   logic [FIR_CW-9:0] hi_q;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
      end else if (byte_take) begin
         case (byte_idx)
            2'd0:    hi_q[FIR_CW-9]   <= byte_in[0];
            2'd1:    hi_q[FIR_CW-10:0] <= byte_in;
            default: ;
         endcase
      end
   end

   // Final byte merges straight through so the loader can register cin on the same edge.
   assign coef_nxt = {hi_q, byte_in};
   assign pad_err  = (byte_idx == 2'd0) && (byte_in[7:1] != 7'd0);

endmodule

// File: rtl/fir_coef_loader.sv
// Purpose: programs the FIR coefficient RAM (cin/caddr/cload) from a byte-serial image.
// Latency: cload rises the cycle after each coefficient's third byte is accepted.
// Backpressure: byte_ready high only while collecting bytes; waits indefinitely on byte_valid.
module fir_coef_loader import fir_pkg::*; #(
   parameter int NTAPS = FIR_NTAPS,
   parameter int AW    = FIR_AW,
   parameter int CW    = FIR_CW
) (
   input  logic                    clk1,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   fir_coef_loader_if.slave        bus,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [7:0]              checksum
);

   state_t            state;
   logic [AW-1:0]     cnt;
   logic [1:0]        byte_idx;
   logic              xfer;
   logic              pad_err;
   logic [FIR_CW-1:0] coef_nxt;

   // Abort wins over a byte offered in the same cycle.
   assign xfer = bus.byte_valid && bus.byte_ready && !abort;

   always_comb begin
      byte_idx = 2'd0;
      case (state)
         ST_B1:   byte_idx = 2'd1;
         ST_B2:   byte_idx = 2'd2;
         default: byte_idx = 2'd0;
      endcase
   end

   fir_coef_asm u_asm (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .byte_in   (bus.byte_in),
      .byte_take (xfer),
      .byte_idx  (byte_idx),
      .coef_nxt  (coef_nxt),
      .pad_err   (pad_err)
   );

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         bus.cin        <= '0;
         bus.caddr      <= '0;
         bus.cload      <= 1'b0;
         bus.byte_ready <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         checksum       <= 8'd0;
      end else begin
         bus.cload <= 1'b0;
         if (xfer) begin
            checksum <= checksum + bus.byte_in;
         end
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state          <= ST_B0;
                  cnt            <= '0;
                  checksum       <= 8'd0;
                  err            <= 1'b0;
                  done           <= 1'b0;
                  busy           <= 1'b1;
                  bus.byte_ready <= 1'b1;
               end
            end
            ST_B0, ST_B1, ST_B2: begin
               if (abort) begin
                  state          <= ST_IDLE;
                  busy           <= 1'b0;
                  done           <= 1'b0;
                  bus.byte_ready <= 1'b0;
               end else if (xfer) begin
                  if (state == ST_B0) begin
                     state <= ST_B1;
                     if (pad_err) begin
                        err <= 1'b1;
                     end
                  end else if (state == ST_B1) begin
                     state <= ST_B2;
                  end else begin
                     state          <= ST_WR;
                     bus.cin        <= CW'(coef_nxt);
                     bus.caddr      <= cnt;
                     bus.cload      <= 1'b1;
                     bus.byte_ready <= 1'b0;
                  end
               end
            end
            ST_WR: begin
               // The strobe for this write is already registered, so abort only stops what follows.
               if (abort) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else if (cnt == AW'(NTAPS - 1)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state          <= ST_B0;
                  cnt            <= cnt + AW'(1);
                  bus.byte_ready <= 1'b1;
               end
            end
            default: begin
               state          <= ST_IDLE;
               busy           <= 1'b0;
               done           <= 1'b0;
               bus.byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Upstream companion to W4823_FIR. It takes a byte-serial coefficient image and programs the FIR's coefficient RAM through the FIR's cin/caddr/cload port. Each coefficient is 17 bits and arrives as three bytes, most significant byte first. The block runs in the FIR's slow clock domain (clk1), so its outputs connect directly to the FIR's cin, caddr and cload.

Parameters:
NTAPS, 64, number of coefficients per load image; caddr counts 0..NTAPS-1.
AW, 6, caddr width; must satisfy 2**AW >= NTAPS.
CW, 17, coefficient width; fixed to match the FIR's cin.

Ports:
clk1  in  1  clock (FIR slow clock domain); all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a load; honoured only in IDLE
abort  in  1  cancel the load in progress; returns the block to IDLE
byte_in  in  8  coefficient byte stream
byte_valid  in  1  byte_in is valid
byte_ready  out  1  block accepts a byte; transfer happens when byte_valid && byte_ready
cin  out  CW  coefficient value to the FIR
caddr  out  AW  coefficient address to the FIR
cload  out  1  one-cycle write strobe to the FIR
busy  out  1  a load is in progress
done  out  1  full image written; held until the next accepted start
err  out  1  sticky format error: a nonzero pad bit was seen in byte 0
checksum  out  8  running sum, mod 256, of every byte accepted in this load

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the internal address counter is 0. Reset is asynchronous and takes effect immediately, including in the middle of a load; coefficients already written to the FIR stay written.
- FSM states: IDLE, B0, B1, B2, WR, DONE. All outputs are registered.
- IDLE
  - start=1 moves to B0.
  - On that same edge: address counter cleared, checksum cleared, err cleared, done cleared.
- B0, B1, B2
  - byte_ready=1 in these states only.
  - The FSM advances only on an accepted byte; byte_valid low means wait indefinitely, with no timeout.
  - B0: coef[16] <= byte_in[0]. If byte_in[7:1] != 0, set err. The load continues regardless.
  - B1: coef[15:8] <= byte_in.
  - B2: coef[7:0] <= byte_in.
- WR
  - Lasts exactly one cycle: cload=1, cin holds the assembled coefficient, caddr holds the address counter.
  - cin and caddr are loaded on the edge that enters WR. They are held unchanged after WR until the next write, so they are stable while cload is high.
  - cload therefore rises on the cycle after the third byte is accepted.
  - Exit: if the counter == NTAPS-1, go to DONE; otherwise increment the counter and go to B0.
- DONE
  - done=1 and busy=0. done stays high while in DONE.
  - start=1 clears done and re-enters B0, with the same clears as from IDLE.
- busy=1 in B0, B1, B2 and WR; 0 otherwise.
- checksum: on every accepted byte, checksum <= checksum + byte_in, with 8-bit wrap.
- abort=1 in any busy state: go to IDLE on the next edge.
  - busy=0 and done=0 afterwards; err and checksum keep their values.
  - If abort is asserted during WR, that cload still completes, because the strobe is already registered.
- abort has priority over a byte transfer arriving in the same cycle; that byte is not consumed.
- start while busy is ignored. abort while IDLE or DONE is ignored.
- Pulse count: exactly NTAPS cload pulses per completed load, with caddr 0,1,...,NTAPS-1 strictly in order.

Decomposition:
- Shared package fir_pkg holds:
  - the FSM state encoding (localparams for IDLE..DONE);
  - FIR_NTAPS=64, FIR_AW=6, FIR_CW=17, shared with W4823_FIR.
- Sub-module fir_coef_asm: 3-byte to 17-bit coefficient assembler. It covers the byte shift/merge and the pad-bit check, and is controlled by a byte-index input from the FSM.
- Address counter, checksum and FSM stay in fir_coef_loader.

Test Plan:
1. Full load, byte_valid held high: coefficient k = {k[0], 8'h00, k[7:0]*3} -> 64 cload pulses, each 4 cycles apart; caddr 0..63; cin matches each coefficient; done=1 after the 64th WR; err=0; checksum = sum of all 192 bytes mod 256.
2. Backpressure: byte_valid randomly low about 50% of cycles with the same image -> identical cin/caddr sequence; cload never asserts while a coefficient is partially received.
3. Pad error: coefficient 5 byte 0 = 8'h03 -> err=1 from the acceptance of that byte; cin for caddr 5 = 17'h1xxxx; load still completes with done=1.
4. Abort: abort asserted during B1 of coefficient 10 -> exactly 10 cload pulses (caddr 0..9); busy=0, done=0 next cycle; the byte offered in the abort cycle is not consumed; a fresh start reloads from caddr 0.
5. Start ignored: start pulsed in B2 of coefficient 3 -> no restart; caddr continues 4,5,...; checksum not cleared.
6. Reset mid-load: rst_n low during WR of coefficient 20 -> all outputs 0 immediately (async); after release the block is in IDLE with byte_ready=0 until the next start.
